suma_serial: RTL and testbench

SUMA_SERIAL -- requirements
Module: suma_serial

---
 rtl/suma_pkg.sv | 14 +
 rtl/sumador_bit.sv | 13 +
 rtl/suma_serial.sv | 109 ++++++++++
 tb/tb_suma_serial.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/suma_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package suma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sumador_bit.sv
// One-bit full adder used once per RUN cycle by the serial adder.
module sumador_bit (
  input  logic ain,
  input  logic bin,
  input  logic cin,
  output logic sum,
  output logic carry_num
);

  assign sum       = ain ^ bin ^ cin;
  assign carry_num = (ain & bin) | (cin & (ain ^ bin));

endmodule

// File: rtl/suma_serial.sv
// Bit-serial N-bit adder: one operand bit per RUN cycle, LSB first; result, carry and
// two's-complement overflow are registered together on the final RUN edge.
module suma_serial
  import suma_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A_num,
  input  logic [N-1:0] B_num,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         ovf
);

  localparam int unsigned CW = cnt_width(N);

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_work;
  logic [CW-1:0]  r_cnt;
  logic           r_c;
  logic [N-1:0]   r_result;
  logic           r_carry;
  logic           r_ovf;

  logic           w_sum;
  logic           w_cout;
  logic           w_last;
  logic           w_accept;

  sumador_bit u_sumador_bit (
    .ain       (r_a[0]),
    .bin       (r_b[0]),
    .cin       (r_c),
    .sum       (w_sum),
    .carry_num (w_cout)
  );

  assign w_last = (r_cnt == CW'(N - 1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE, FIN: begin
        if (start) begin
          w_state_next = RUN;
          w_accept     = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) w_state_next = FIN;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_c      <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a    <= A_num;
      r_b    <= B_num;
      r_work <= '0;
      r_cnt  <= '0;
      r_c    <= 1'b0;
    end else if (r_state == RUN) begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_work <= {w_sum, r_work[N-1:1]};
      r_c    <= w_cout;
      r_cnt  <= r_cnt + CW'(1);
      // On the MSB, r_c is the carry into the MSB, so overflow is its XOR with carry out
      if (w_last) begin
        r_result <= {w_sum, r_work[N-1:1]};
        r_carry  <= w_cout;
        r_ovf    <= r_c ^ w_cout;
      end
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == FIN);
  assign result = r_result;
  assign carry  = r_carry;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_suma_serial.sv
// Randomized and directed bench for suma_serial against an arithmetic reference model.
module tb_suma_serial;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] A_num;
  logic [N-1:0] B_num;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         carry;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  suma_serial #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A_num  (A_num),
    .B_num  (B_num),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Returns {ovf, carry, result} computed from plain integer arithmetic.
  function automatic logic [N+1:0] ref_sum(input int a, input int b);
    int s, sa, sb, ss;
    logic cy, ov;
    s  = a + b;
    cy = (s >= 2 ** N);
    sa = (a >= 2 ** (N - 1)) ? a - 2 ** N : a;
    sb = (b >= 2 ** (N - 1)) ? b - 2 ** N : b;
    ss = sa + sb;
    ov = (ss > 2 ** (N - 1) - 1) || (ss < -(2 ** (N - 1)));
    return {ov, cy, N'(s)};
  endfunction

  task automatic check_outputs(input string tag, input logic [N+1:0] exp);
    check({tag, "_result"}, 32'(result), 32'(exp[N-1:0]));
    check({tag, "_carry"},  32'(carry),  32'(exp[N]));
    check({tag, "_ovf"},    32'(ovf),    32'(exp[N+1]));
  endtask

  // Single start pulse; operands scrambled after acceptance to prove they were captured.
  task automatic run_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N+1:0] exp;
    int j;
    exp = ref_sum(int'(a), int'(b));
    @(negedge clk);
    start = 1'b1; A_num = a; B_num = b;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    j = 1;
    while (!done && j < 4 * N) begin
      A_num = N'($urandom);
      B_num = N'($urandom);
      @(negedge clk);
      j++;
    end
    check("latency", 32'(j), 32'(N + 1));
    check_outputs("add", exp);
    @(negedge clk);
    check("done_single_cycle", 32'(done), 32'd0);
    check("result_hold", 32'(result), 32'(exp[N-1:0]));
  endtask

  // start held high: operands changed during RUN are taken only at the FIN edge.
  task automatic back_to_back(input logic [N-1:0] a1, input logic [N-1:0] b1,
                              input logic [N-1:0] a2, input logic [N-1:0] b2);
    logic [N+1:0] exp1, exp2;
    int j;
    exp1 = ref_sum(int'(a1), int'(b1));
    exp2 = ref_sum(int'(a2), int'(b2));
    @(negedge clk);
    start = 1'b1; A_num = a1; B_num = b1;
    @(negedge clk);
    A_num = a2; B_num = b2;
    j = 1;
    while (!done && j < 4 * N) begin
      @(negedge clk);
      j++;
    end
    check("b2b_latency1", 32'(j), 32'(N + 1));
    check_outputs("b2b_first", exp1);
    j = 0;
    do begin
      @(negedge clk);
      j++;
      if (j == 1) begin
        start = 1'b0;
        check("b2b_no_idle_gap", 32'(busy), 32'd1);
      end
    end while (!done && j < 4 * N);
    check("b2b_spacing", 32'(j), 32'(N + 1));
    check_outputs("b2b_second", exp2);
  endtask

  initial begin
    logic saw_done;
    rst_n = 1'b0; start = 1'b0; A_num = '0; B_num = '0;
    #12;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry",  32'(carry),  32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_add(4'd3,  4'd4);
    run_add(4'd15, 4'd1);
    run_add(4'd7,  4'd1);
    run_add(4'd8,  4'd8);

    back_to_back(4'd3, 4'd4, 4'd9, 4'd2);
    @(negedge clk);
    back_to_back(4'd1, 4'd2, 4'd5, 4'd5);
    @(negedge clk);

    // Abort mid-RUN after a non-zero result is on the outputs
    run_add(4'd3, 4'd4);
    @(negedge clk);
    start = 1'b1; A_num = 4'd6; B_num = 4'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_done",   32'(done),   32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_carry",  32'(carry),  32'd0);
    check("abort_ovf",    32'(ovf),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (N + 3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    for (int i = 0; i < 20; i++) begin
      run_add(N'($urandom), N'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
